// File: rtl/ordenador_seq_if.sv
// Handshake bundle for ordenador_seq: producer side (in_*) and consumer side (out_*).
// The slave modport is the sorter; the master modport is whoever feeds and drains it.
interface ordenador_seq_if #(
  parameter int SIZE = 8,
  parameter int N    = 8
);
  logic                     in_valid;
  logic                     in_ready;
  logic [N*SIZE-1:0]        in_data;
  logic                     in_desc;
  logic                     out_valid;
  logic                     out_ready;
  logic [N*SIZE-1:0]        out_data;
  logic [$clog2(N+1)-1:0]   out_passes;

  modport slave (
    input  in_valid, in_data, in_desc, out_ready,
    output in_ready, out_valid, out_data, out_passes
  );

  modport master (
    output in_valid, in_data, in_desc, out_ready,
    input  in_ready, out_valid, out_data, out_passes
  );
endinterface

// File: rtl/ordenador_seq.sv
// Iterative odd-even transposition sorter: one row of compare-exchange cells reused for N passes.
// Optional early exit (two consecutive swap-free passes) is enabled by defining ORD_EARLY_EXIT_EN.
module ordenador_seq #(
  parameter int SIZE = 8,
  parameter int N    = 8
) (
  input  logic           clk,
  input  logic           rst_n,
  ordenador_seq_if.slave bus
);
  localparam int PW = $clog2(N + 1);
  localparam logic [PW-1:0] LAST_PASS = PW'(N - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SORT = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t state_reg, state_next;

  logic [N-1:0][SIZE-1:0] lane_reg;
  logic [N-1:0][SIZE-1:0] even_res;
  logic [N-1:0][SIZE-1:0] odd_res;
  logic [N/2-1:0]         even_swap;
  logic [N/2-1:0]         odd_swap;
  logic                   desc_reg;
  logic [PW-1:0]          pass_reg;
  logic                   accept;

`ifdef ORD_EARLY_EXIT_EN
  logic                   pass_swap;
  logic                   swap_prev_reg;
`endif

  // Even pass: pairs (0,1), (2,3), ... cover every lane.
  genvar gi;
  generate
    for (gi = 0; gi < N/2; gi++) begin : g_even
      logic lo_gt_hi;
      logic lo_lt_hi;
      assign lo_gt_hi = lane_reg[2*gi] > lane_reg[2*gi+1];
      assign lo_lt_hi = lane_reg[2*gi] < lane_reg[2*gi+1];
      assign even_swap[gi] = desc_reg ? lo_lt_hi : lo_gt_hi;
      assign even_res[2*gi]   = even_swap[gi] ? lane_reg[2*gi+1] : lane_reg[2*gi];
      assign even_res[2*gi+1] = even_swap[gi] ? lane_reg[2*gi]   : lane_reg[2*gi+1];
    end

    // Odd pass: pairs (1,2), ..., (N-3,N-2); the outer lanes pass through.
    for (gi = 0; gi < N/2 - 1; gi++) begin : g_odd
      logic lo_gt_hi;
      logic lo_lt_hi;
      assign lo_gt_hi = lane_reg[2*gi+1] > lane_reg[2*gi+2];
      assign lo_lt_hi = lane_reg[2*gi+1] < lane_reg[2*gi+2];
      assign odd_swap[gi] = desc_reg ? lo_lt_hi : lo_gt_hi;
      assign odd_res[2*gi+1] = odd_swap[gi] ? lane_reg[2*gi+2] : lane_reg[2*gi+1];
      assign odd_res[2*gi+2] = odd_swap[gi] ? lane_reg[2*gi+1] : lane_reg[2*gi+2];
    end
  endgenerate

  assign odd_res[0]          = lane_reg[0];
  assign odd_res[N-1]        = lane_reg[N-1];
  assign odd_swap[N/2-1]     = 1'b0;

  assign accept = bus.in_valid && (state_reg == IDLE);

`ifdef ORD_EARLY_EXIT_EN
  assign pass_swap = pass_reg[0] ? (|odd_swap) : (|even_swap);
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE: begin
        if (bus.in_valid) state_next = SORT;
      end
      SORT: begin
        if (pass_reg == LAST_PASS) begin
          state_next = DONE;
        end
`ifdef ORD_EARLY_EXIT_EN
        // Two clean passes in a row means every adjacent pair is already ordered.
        else if ((pass_reg != '0) && !pass_swap && !swap_prev_reg) begin
          state_next = DONE;
        end
`endif
      end
      DONE: begin
        if (bus.out_ready) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    bus.in_ready  = 1'b0;
    bus.out_valid = 1'b0;
    case (state_reg)
      IDLE:    bus.in_ready  = 1'b1;
      DONE:    bus.out_valid = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lane_reg      <= '0;
      desc_reg      <= 1'b0;
      pass_reg      <= '0;
`ifdef ORD_EARLY_EXIT_EN
      swap_prev_reg <= 1'b0;
`endif
    end else if (accept) begin
      lane_reg      <= bus.in_data;
      desc_reg      <= bus.in_desc;
      pass_reg      <= '0;
`ifdef ORD_EARLY_EXIT_EN
      swap_prev_reg <= 1'b0;
`endif
    end else if (state_reg == SORT) begin
      lane_reg      <= pass_reg[0] ? odd_res : even_res;
      pass_reg      <= pass_reg + PW'(1);
`ifdef ORD_EARLY_EXIT_EN
      swap_prev_reg <= pass_swap;
`endif
    end
  end

  // pass_reg ends each operation holding the number of passes executed.
  assign bus.out_data   = lane_reg;
  assign bus.out_passes = pass_reg;
endmodule

// File: tb/tb_ordenador_seq.sv
// Scoreboard bench for ordenador_seq: stimulus pushes software-sorted expectations,
// a negedge monitor pops and compares on every output handshake.
module tb_ordenador_seq;
  localparam int SIZE = 8;
  localparam int N    = 8;
  localparam int W    = N * SIZE;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;

  ordenador_seq_if #(.SIZE(SIZE), .N(N)) bus ();
  ordenador_seq #(.SIZE(SIZE), .N(N)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  int cyc    = 0;
  int hs_edge = 0;
  int nres   = 0;
  int rdy_mode = 0;

  logic [W-1:0] exp_q[$];
  int           acc_q[$];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(string name, logic [W-1:0] got, logic [W-1:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  function automatic logic [W-1:0] ref_sort(logic [W-1:0] v, logic desc);
    int q[$];
    logic [W-1:0] r;
    r = '0;
    for (int i = 0; i < N; i++) q.push_back(int'(v[i*SIZE +: SIZE]));
    q.sort();
    for (int i = 0; i < N; i++) r[i*SIZE +: SIZE] = SIZE'(q[desc ? (N - 1 - i) : i]);
    return r;
  endfunction

  function automatic logic [W-1:0] mk(int a[N]);
    logic [W-1:0] r;
    for (int i = 0; i < N; i++) r[i*SIZE +: SIZE] = SIZE'(a[i]);
    return r;
  endfunction

  task automatic send(logic [W-1:0] v, logic desc, output int acc_edge);
    int n;
    n = 0;
    acc_edge = -1;
    @(posedge clk); #1;
    bus.in_valid = 1'b1;
    bus.in_data  = v;
    bus.in_desc  = desc;
    forever begin
      @(negedge clk);
      if (bus.in_ready) break;
      n++;
      if (n > 200) begin
        checks++; errors++;
        $display("FAIL accept_timeout: got in_ready=0 for %0d cycles expected an accept", n);
        break;
      end
    end
    if (bus.in_ready) begin
      exp_q.push_back(ref_sort(v, desc));
      acc_edge = cyc + 1;
      acc_q.push_back(acc_edge);
    end
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    bus.in_data  = {$urandom, $urandom};
    bus.in_desc  = 1'($urandom_range(0, 1));
  endtask

  task automatic wait_drain();
    int n;
    n = 0;
    while (exp_q.size() != 0) begin
      @(negedge clk);
      n++;
      if (n > 300) begin
        checks++; errors++;
        $display("FAIL drain_timeout: got %0d pending results expected 0", exp_q.size());
        exp_q.delete(); acc_q.delete();
        break;
      end
    end
    @(negedge clk);
  endtask

  always @(posedge clk) begin
    if (rdy_mode == 1) begin
      #1 bus.out_ready = 1'($urandom_range(0, 1));
    end
  end

  // Monitor: latency, hold during stall, and data on each handshake.
  logic         prev_valid = 1'b0;
  logic [W-1:0] held_data;
  always @(negedge clk) begin
    if (!rst_n) begin
      prev_valid = 1'b0;
    end else begin
      if (bus.out_valid) begin
        check("in_ready_in_done", W'(bus.in_ready), W'(0));
        if (!prev_valid) begin
          if (acc_q.size() == 0) begin
            checks++; errors++;
            $display("FAIL spurious_result: got out_valid=1 expected no pending vector");
          end else begin
            int lat;
            lat = cyc - acc_q.pop_front();
`ifdef ORD_EARLY_EXIT_EN
            checks++;
            if (bus.out_passes < 2 || bus.out_passes > N) begin
              errors++;
              $display("FAIL passes_range: got %0d expected 2..%0d", bus.out_passes, N);
            end
            check("latency", W'(lat), W'(bus.out_passes));
`else
            check("passes", W'(bus.out_passes), W'(N));
            check("latency", W'(lat), W'(N));
`endif
          end
        end else begin
          check("hold_data", bus.out_data, held_data);
        end
        held_data = bus.out_data;
        if (bus.out_ready) begin
          hs_edge = cyc + 1;
          nres++;
          $display("result %0d: data=%h passes=%0d", nres, bus.out_data, bus.out_passes);
          if (exp_q.size() == 0) begin
            checks++; errors++;
            $display("FAIL no_expectation: got %h expected nothing", bus.out_data);
          end else begin
            check("sorted_data", bus.out_data, exp_q.pop_front());
          end
        end
      end
      prev_valid = bus.out_valid;
    end
  end

  initial begin
    int a[N];
    int acc;
    int n;
    logic [W-1:0] v;
    logic [W-1:0] cap;

    bus.in_valid  = 1'b0;
    bus.in_data   = '0;
    bus.in_desc   = 1'b0;
    bus.out_ready = 1'b1;

    // Reset values
    @(negedge clk);
    check("rst_in_ready", W'(bus.in_ready), W'(1));
    check("rst_out_valid", W'(bus.out_valid), W'(0));
    check("rst_out_data", bus.out_data, W'(0));
    check("rst_out_passes", W'(bus.out_passes), W'(0));
    @(posedge clk); #1 rst_n = 1'b1;

    // Directed: reverse ascending, already-ordered descending, duplicates/extremes
    a = '{8, 7, 6, 5, 4, 3, 2, 1};
    send(mk(a), 1'b0, acc); wait_drain();
    send(mk(a), 1'b1, acc); wait_drain();
    a = '{255, 0, 255, 0, 7, 7, 128, 1};
    send(mk(a), 1'b0, acc); wait_drain();
    a = '{0, 0, 1, 7, 7, 128, 255, 255};
    check("model_extremes", ref_sort(mk('{255, 0, 255, 0, 7, 7, 128, 1}), 1'b0), mk(a));

    // Backpressure then back-to-back
    bus.out_ready = 1'b0;
    a = '{3, 9, 1, 200, 42, 42, 0, 17};
    send(mk(a), 1'b0, acc);
    n = 0;
    while (!bus.out_valid && n < 100) begin @(negedge clk); n++; end
    check("stall_reached_done", W'(bus.out_valid), W'(1));
    cap = bus.out_data;
    repeat (5) begin
      @(negedge clk);
      check("stall_data", bus.out_data, cap);
      check("stall_valid", W'(bus.out_valid), W'(1));
      check("stall_in_ready", W'(bus.in_ready), W'(0));
    end
    @(posedge clk); #1 bus.out_ready = 1'b1;
    a = '{5, 4, 250, 6, 6, 1, 99, 2};
    send(mk(a), 1'b1, acc);
    check("back_to_back", W'(acc - hs_edge), W'(1));
    wait_drain();

    // Reset abort at pass 3
    a = '{1, 2, 3, 4, 5, 6, 7, 8};
    send(mk(a), 1'b1, acc);
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b0;
    @(negedge clk);
    check("abort_out_valid", W'(bus.out_valid), W'(0));
    check("abort_in_ready", W'(bus.in_ready), W'(1));
    check("abort_out_data", bus.out_data, W'(0));
    exp_q.delete();
    acc_q.delete();
    @(posedge clk); #1 rst_n = 1'b1;
    a = '{77, 12, 0, 255, 12, 3, 90, 41};
    send(mk(a), 1'b0, acc); wait_drain();

    // Random regression with random out_ready
    rdy_mode = 1;
    for (int k = 0; k < 400; k++) begin
      for (int i = 0; i < N; i++) begin
        if (k % 3 == 0) v[i*SIZE +: SIZE] = SIZE'($urandom_range(0, 3));
        else            v[i*SIZE +: SIZE] = SIZE'($urandom_range(0, 255));
      end
      send(v, 1'($urandom_range(0, 1)), acc);
    end
    wait_drain();
    rdy_mode = 0;
    @(posedge clk); #1 bus.out_ready = 1'b1;
    wait_drain();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
